door_controller: RTL and testbench
==================================

# door_controller

Cabin-door sequencer that sits around `frequency_door`. It consumes the slow `door_clk` tick that `frequency_door` produces and steps the door through open, dwell and close phases. It produces `move_handler`, which tells the car-motion logic when the door is safely shut. Obstruction, overweight and cabin open/close buttons are arbitrated here, and repeated reopen events are escalated to a sticky fault.

## Interface
Parameters:
- `OPEN_TICKS`, default 3: number of `door_clk` rising edges the door dwells in OPEN.
- `MAX_REOPEN`, default 3: number of CLOSING→OPENING reversals allowed per cycle before fault.

Ports:
- `clk` — in, 1: system clock.
- `button_reset` — in, 1: asynchronous, active-low reset (0 = reset).
- `door_clk` — in, 1: slow toggle from `frequency_door`, synchronous to `clk`.
- `arrive` — in, 1: one-`clk` pulse when the car has stopped at a served floor.
- `open_request` — in, 1: cabin open button, one-`clk` pulse.
- `close_request` — in, 1: cabin close button, one-`clk` pulse.
- `obstruction` — in, 1: door-edge sensor, level.
- `weight_limit_exceeded` — in, 1: overweight sensor, level.
- `door_state` — out, 2: 0 CLOSED, 1 OPENING, 2 OPEN, 3 CLOSING.
- `door_open` — out, 1: high whenever `door_state` ≠ CLOSED.
- `move_handler` — out, 1: high means the car may move.
- `door_fault` — out, 1: sticky reopen-limit fault.

## Operation
- **Tick detection**
  - Register `door_clk_q`.
  - `tick` = `door_clk & ~door_clk_q`.
  - State logic acts on `tick` at the same `clk` edge.
- **Reopen trigger**
  - `reopen` = `obstruction | weight_limit_exceeded | open_request`.
- **CLOSED**
  - `arrive` or `open_request` → OPENING; ticks are ignored.
  - Otherwise stay CLOSED.
- **OPENING**
  - On `tick` → OPEN; dwell counter loads `OPEN_TICKS`.
- **OPEN**
  - `tick` decrements the dwell counter.
  - Counter reaches 0 with `obstruction` = 0 and `weight_limit_exceeded` = 0 → CLOSING.
  - Counter at 0 with either sensor high: stay OPEN, counter held at 0.
  - `open_request` reloads the counter to `OPEN_TICKS`.
  - `close_request` forces the counter to 0; CLOSING follows on the next `clk` if both sensors are low, with no tick required.
  - When `open_request` and `close_request` arrive together, `open_request` wins.
- **CLOSING**
  - `reopen` high → OPENING on the next `clk`, no tick required; reopen counter +1.
  - Otherwise `tick` → CLOSED and the reopen counter clears.
- **Fault**
  - When an increment makes the reopen counter equal `MAX_REOPEN`, set `door_fault`.
  - State goes to OPEN and stays OPEN: ticks, `close_request` and dwell are ignored.
  - Cleared only by reset.
- **`move_handler`**
  - Registered: 1 when the next state is CLOSED, not entering OPENING, and `door_fault` = 0.
  - Drops on the same edge that leaves CLOSED.
- **Counters**
  - Dwell counter width is `$clog2(OPEN_TICKS+1)`.
  - Reopen counter width is `$clog2(MAX_REOPEN+1)`, saturating.
  - No wrap-around is permitted.
- **Upstream coupling:** `weight_limit_exceeded` also freezes `door_clk` upstream, so ticks stop; the hold behaviour above applies regardless.

## Timing
- **Reset values:**
  - `door_state` = CLOSED, `door_open` = 0, `move_handler` = 0, `door_fault` = 0.
  - Dwell and reopen counters = 0, `door_clk_q` = 0.
- **After reset release:**
  - `move_handler` rises at the first `clk` edge.
  - If `door_clk` is already high at release, the first edge counts as a tick; it is ignored in CLOSED.
- **Latencies:**
  - `door_clk` rise → state change: 1 `clk` edge.
  - `arrive` → OPENING and `move_handler` = 0: 1 edge.
  - `reopen` in CLOSING → OPENING: 1 edge.
- **Full open-close sequence with no interference:** 1 tick (OPENING) + `OPEN_TICKS` ticks (OPEN) + 1 tick (CLOSING).
- **Simultaneous events:**
  - `tick` and `reopen` in CLOSING: reopen wins.
  - `tick` and `close_request` in OPEN: CLOSING.
  - `arrive` outside CLOSED: ignored.
- **Reset mid-operation:** immediate return to CLOSED with all outputs at reset values; no partial state survives.

## Test plan
All scenarios use `OPEN_TICKS` = 2 and `MAX_REOPEN` = 2.
- **Basic cycle:** reset, release, `arrive` pulse → `door_state` 1, then 2 after 1 tick, 3 after 2 more ticks, 0 after 1 more tick; `move_handler` 0 throughout and 1 on return to CLOSED.
- **Close button:** `close_request` in OPEN right after entry → CLOSING on the next `clk` edge without waiting for a tick.
- **Overweight hold:** `weight_limit_exceeded` high in OPEN and ticks stopped → stays in state 2 for 1000 `clk`; after the sensor drops and 2 ticks → CLOSING.
- **Obstruction reversal:** `obstruction` high in CLOSING → OPENING at the next edge; a second reversal → `door_fault` = 1, state 2 held.
- **Fault lock:** with `door_fault` = 1, 10 ticks plus `close_request` → state stays 2; assert `button_reset` = 0 mid-hold → state 0, all outputs 0.
- **Simultaneous events:**
  - `open_request` and `close_request` in the same cycle in OPEN → dwell reloads to 2 and the state stays OPEN.
  - `tick` and `obstruction` in the same cycle in CLOSING → OPENING.

Source files
------------

// File: rtl/door_controller.sv
// Cabin-door sequencer: steps the door CLOSED->OPENING->OPEN->CLOSING on door_clk ticks,
// arbitrates sensors and buttons, and locks the door open after too many reversals.
module door_controller #(
   parameter int OPEN_TICKS = 3,
   parameter int MAX_REOPEN = 3
) (
   input  logic       clk,
   input  logic       button_reset,
   input  logic       door_clk,
   input  logic       arrive,
   input  logic       open_request,
   input  logic       close_request,
   input  logic       obstruction,
   input  logic       weight_limit_exceeded,
   output logic [1:0] door_state,
   output logic       door_open,
   output logic       move_handler,
   output logic       door_fault
);

   localparam int DW = (OPEN_TICKS > 0) ? $clog2(OPEN_TICKS + 1) : 1;
   localparam int RW = (MAX_REOPEN > 0) ? $clog2(MAX_REOPEN + 1) : 1;
   localparam logic [DW-1:0] LP_OPEN = DW'(OPEN_TICKS);
   localparam logic [RW-1:0] LP_RMAX = RW'(MAX_REOPEN);

   typedef enum logic [1:0] {
      ST_CLOSED  = 2'd0,
      ST_OPENING = 2'd1,
      ST_OPEN    = 2'd2,
      ST_CLOSING = 2'd3
   } state_t;

   state_t        r_state;
   logic          r_door_clk_q;
   logic [DW-1:0] r_dwell;
   logic [RW-1:0] r_reopen;
   logic          r_fault;
   logic          r_door_open;
   logic          r_move;

   state_t        w_state_nxt;
   logic [DW-1:0] w_dwell_nxt;
   logic [DW-1:0] w_dwell_eff;
   logic [RW-1:0] w_reopen_nxt;
   logic [RW-1:0] w_reopen_inc;
   logic          w_fault_nxt;
   logic          w_tick;
   logic          w_sensor;
   logic          w_reopen_ev;

   assign w_tick      = door_clk & ~r_door_clk_q;
   assign w_sensor    = obstruction | weight_limit_exceeded;
   assign w_reopen_ev = w_sensor | open_request;
   // Saturate so a stuck sensor can never wrap the reversal count back to zero.
   assign w_reopen_inc = (r_reopen == LP_RMAX) ? r_reopen : r_reopen + RW'(1);

   // Dwell value as seen after this cycle's button/tick events; open beats close.
   always_comb begin
      w_dwell_eff = r_dwell;
      if (open_request)
         w_dwell_eff = LP_OPEN;
      else if (close_request)
         w_dwell_eff = '0;
      else if (w_tick && (r_dwell != '0))
         w_dwell_eff = r_dwell - DW'(1);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_dwell_nxt  = r_dwell;
      w_reopen_nxt = r_reopen;
      w_fault_nxt  = r_fault;
      if (r_fault) begin
         w_state_nxt = ST_OPEN;
      end else begin
         case (r_state)
            ST_CLOSED: begin
               if (arrive || open_request)
                  w_state_nxt = ST_OPENING;
            end
            ST_OPENING: begin
               if (w_tick) begin
                  w_state_nxt = ST_OPEN;
                  w_dwell_nxt = LP_OPEN;
               end
            end
            ST_OPEN: begin
               w_dwell_nxt = w_dwell_eff;
               if ((w_dwell_eff == '0) && !w_sensor)
                  w_state_nxt = ST_CLOSING;
            end
            ST_CLOSING: begin
               if (w_reopen_ev) begin
                  w_reopen_nxt = w_reopen_inc;
                  if (w_reopen_inc == LP_RMAX) begin
                     w_fault_nxt = 1'b1;
                     w_state_nxt = ST_OPEN;
                  end else begin
                     w_state_nxt = ST_OPENING;
                  end
               end else if (w_tick) begin
                  w_state_nxt  = ST_CLOSED;
                  w_reopen_nxt = '0;
               end
            end
            default: w_state_nxt = ST_CLOSED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge button_reset) begin
      if (!button_reset) begin
         r_state      <= ST_CLOSED;
         r_door_clk_q <= 1'b0;
         r_dwell      <= '0;
         r_reopen     <= '0;
         r_fault      <= 1'b0;
         r_door_open  <= 1'b0;
         r_move       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_door_clk_q <= door_clk;
         r_dwell      <= w_dwell_nxt;
         r_reopen     <= w_reopen_nxt;
         r_fault      <= w_fault_nxt;
         r_door_open  <= (w_state_nxt != ST_CLOSED);
         r_move       <= (w_state_nxt == ST_CLOSED) && !w_fault_nxt;
      end
   end

   assign door_state   = r_state;
   assign door_open    = r_door_open;
   assign move_handler = r_move;
   assign door_fault   = r_fault;

endmodule

// File: tb/tb_door_controller.sv
// Directed scoreboard bench for door_controller with OPEN_TICKS=2, MAX_REOPEN=2.
module tb_door_controller;

   logic       clk;
   logic       button_reset;
   logic       door_clk;
   logic       arrive;
   logic       open_request;
   logic       close_request;
   logic       obstruction;
   logic       weight_limit_exceeded;
   logic [1:0] door_state;
   logic       door_open;
   logic       move_handler;
   logic       door_fault;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] st;
      logic       op;
      logic       mv;
      logic       ft;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];

   door_controller #(.OPEN_TICKS(2), .MAX_REOPEN(2)) dut (
      .clk                   (clk),
      .button_reset          (button_reset),
      .door_clk              (door_clk),
      .arrive                (arrive),
      .open_request          (open_request),
      .close_request         (close_request),
      .obstruction           (obstruction),
      .weight_limit_exceeded (weight_limit_exceeded),
      .door_state            (door_state),
      .door_open             (door_open),
      .move_handler          (move_handler),
      .door_fault            (door_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_out(input string tag, input logic [1:0] st, input logic mv, input logic ft);
      exp_t e;
      e.st = st;
      e.op = (st != 2'd0);
      e.mv = mv;
      e.ft = ft;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic chk();
      exp_t        e;
      string       t;
      logic [4:0]  obs;
      logic [4:0]  req;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         t   = tag_q.pop_front();
         req = e;
         obs = {door_state, door_open, move_handler, door_fault};
         checks++;
         assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed={st,open,move,fault}=%b required=%b", t, obs, req);
         end
      end
   endtask

   // One clk edge; single-cycle pulses are cleared just after it.
   task automatic cyc();
      @(posedge clk);
      #1;
      arrive        = 1'b0;
      open_request  = 1'b0;
      close_request = 1'b0;
   endtask

   // A door_clk rise seen at the first edge, then the level drops again.
   task automatic tick();
      door_clk = 1'b1;
      cyc();
      door_clk = 1'b0;
      cyc();
   endtask

   initial begin
      button_reset          = 1'b0;
      door_clk              = 1'b0;
      arrive                = 1'b0;
      open_request          = 1'b0;
      close_request         = 1'b0;
      obstruction           = 1'b0;
      weight_limit_exceeded = 1'b0;
      cyc(); cyc();
      expect_out("reset", 2'd0, 1'b0, 1'b0); chk();

      button_reset = 1'b1;
      expect_out("move_rise", 2'd0, 1'b1, 1'b0); cyc(); chk();
      expect_out("closed_tick_ignored", 2'd0, 1'b1, 1'b0); tick(); chk();

      // Basic cycle
      arrive = 1'b1;
      expect_out("arrive_opening", 2'd1, 1'b0, 1'b0); cyc(); chk();
      expect_out("basic_open", 2'd2, 1'b0, 1'b0); tick(); chk();
      arrive = 1'b1;
      expect_out("arrive_ignored", 2'd2, 1'b0, 1'b0); cyc(); chk();
      expect_out("basic_dwell1", 2'd2, 1'b0, 1'b0); tick(); chk();
      expect_out("basic_closing", 2'd3, 1'b0, 1'b0); tick(); chk();
      expect_out("basic_closed", 2'd0, 1'b1, 1'b0); tick(); chk();

      // Close button right after entering OPEN
      arrive = 1'b1; cyc(); tick();
      close_request = 1'b1;
      expect_out("close_btn", 2'd3, 1'b0, 1'b0); cyc(); chk();
      expect_out("close_btn_closed", 2'd0, 1'b1, 1'b0); tick(); chk();

      // Overweight hold with ticks stopped
      arrive = 1'b1; cyc(); tick();
      weight_limit_exceeded = 1'b1;
      expect_out("ovw_hold", 2'd2, 1'b0, 1'b0);
      repeat (1000) cyc();
      chk();
      weight_limit_exceeded = 1'b0;
      expect_out("ovw_tick1", 2'd2, 1'b0, 1'b0); tick(); chk();
      expect_out("ovw_closing", 2'd3, 1'b0, 1'b0); tick(); chk();
      tick();

      // Obstruction while dwell is already 0: hold, then close without a tick
      arrive = 1'b1; cyc(); tick();
      obstruction = 1'b1;
      tick(); tick();
      expect_out("obs_hold_zero", 2'd2, 1'b0, 1'b0); cyc(); chk();
      obstruction = 1'b0;
      expect_out("obs_release_close", 2'd3, 1'b0, 1'b0); cyc(); chk();
      tick();

      // open_request and close_request together reload dwell
      arrive = 1'b1; cyc(); tick(); tick();
      open_request  = 1'b1;
      close_request = 1'b1;
      expect_out("both_btn_stay", 2'd2, 1'b0, 1'b0); cyc(); chk();
      expect_out("both_btn_reload", 2'd2, 1'b0, 1'b0); tick(); chk();
      expect_out("both_btn_closing", 2'd3, 1'b0, 1'b0); tick(); chk();
      tick();

      // tick and obstruction together in CLOSING: one reversal, then cleared on close
      arrive = 1'b1; cyc(); tick();
      close_request = 1'b1; cyc();
      obstruction = 1'b1;
      door_clk    = 1'b1;
      expect_out("tick_obs_reopen", 2'd1, 1'b0, 1'b0); cyc(); chk();
      door_clk    = 1'b0;
      obstruction = 1'b0;
      cyc(); tick();
      close_request = 1'b1; cyc();
      expect_out("reopen_cnt_cleared", 2'd0, 1'b1, 1'b0); tick(); chk();

      // Two reversals in one cycle escalate to fault
      arrive = 1'b1; cyc(); tick();
      close_request = 1'b1; cyc();
      obstruction = 1'b1;
      expect_out("reversal1", 2'd1, 1'b0, 1'b0); cyc(); chk();
      obstruction = 1'b0;
      tick();
      close_request = 1'b1; cyc();
      obstruction = 1'b1;
      expect_out("reversal2_fault", 2'd2, 1'b0, 1'b1); cyc(); chk();
      obstruction = 1'b0;

      // Fault lock: ticks and close button are ignored
      repeat (10) tick();
      close_request = 1'b1;
      expect_out("fault_lock", 2'd2, 1'b0, 1'b1); cyc(); chk();
      button_reset = 1'b0;
      #2;
      expect_out("async_reset", 2'd0, 1'b0, 1'b0); chk();
      cyc();
      button_reset = 1'b1;
      expect_out("post_reset_move", 2'd0, 1'b1, 1'b0); cyc(); chk();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
